// File: rtl/vga_timing_if.sv
// Raster timing bundle from vga_timing_gen to the colour stage and region decoders.
`timescale 1ns/1ps
interface vga_timing_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              hsync;
    logic              vsync;
    logic              ready_sig;
    logic [ADDR_W-1:0] column_addr;
    logic [ADDR_W-1:0] row_addr;
    logic              frame_start;

    modport master (
        output hsync, vsync, ready_sig, column_addr, row_addr, frame_start
    );

    modport slave (
        input hsync, vsync, ready_sig, column_addr, row_addr, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing: h/v counters with registered sync, visible-window and address decode.
// Optional macro PIXEL_DIV_EN: one pixel tick every 2 clk via an internal pix_en toggle.
`timescale 1ns/1ps
module vga_timing_gen #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned SYNC_POL = 0,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_timing_if.master vga
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned H_START = H_SYNC + H_BACK;
    localparam int unsigned V_START = V_SYNC + V_BACK;
    localparam int unsigned H_END   = H_START + H_ACTIVE;
    localparam int unsigned V_END   = V_START + V_ACTIVE;

    localparam logic SYNC_ON  = 1'(SYNC_POL);
    localparam logic SYNC_OFF = ~SYNC_ON;

    logic [ADDR_W-1:0] h_cnt;
    logic [ADDR_W-1:0] v_cnt;
    logic [ADDR_W-1:0] h_nxt_c;
    logic [ADDR_W-1:0] v_nxt_c;
    logic              tick_c;

    logic              hsync_c;
    logic              vsync_c;
    logic              h_vis_c;
    logic              v_vis_c;
    logic              ready_c;
    logic [ADDR_W-1:0] col_c;
    logic [ADDR_W-1:0] row_c;
    logic              frame_start_c;

`ifdef PIXEL_DIV_EN
    // pix_en is 0 on the first edge after release, so the first update lands on the 2nd edge
    logic pix_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_en <= 1'b0;
        end else begin
            pix_en <= ~pix_en;
        end
    end

    assign tick_c = pix_en;
`else
    assign tick_c = 1'b1;
`endif

    // Counter advance: h wraps at end of line and carries into v, v wraps at end of frame
    always_comb begin
        h_nxt_c = h_cnt + ADDR_W'(1);
        v_nxt_c = v_cnt;
        if (h_cnt == ADDR_W'(H_TOTAL - 1)) begin
            h_nxt_c = '0;
            if (v_cnt == ADDR_W'(V_TOTAL - 1)) begin
                v_nxt_c = '0;
            end else begin
                v_nxt_c = v_cnt + ADDR_W'(1);
            end
        end
    end

    // Decode of the current counter values; registered below so outputs lag counters by one tick
    always_comb begin
        hsync_c       = (h_cnt < ADDR_W'(H_SYNC)) ? SYNC_ON : SYNC_OFF;
        vsync_c       = (v_cnt < ADDR_W'(V_SYNC)) ? SYNC_ON : SYNC_OFF;
        h_vis_c       = (h_cnt >= ADDR_W'(H_START)) && (h_cnt < ADDR_W'(H_END));
        v_vis_c       = (v_cnt >= ADDR_W'(V_START)) && (v_cnt < ADDR_W'(V_END));
        ready_c       = h_vis_c && v_vis_c;
        col_c         = '0;
        row_c         = '0;
        if (ready_c) begin
            col_c = h_cnt - ADDR_W'(H_START);
            row_c = v_cnt - ADDR_W'(V_START);
        end
        frame_start_c = (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt           <= '0;
            v_cnt           <= '0;
            vga.hsync       <= SYNC_OFF;
            vga.vsync       <= SYNC_OFF;
            vga.ready_sig   <= 1'b0;
            vga.column_addr <= '0;
            vga.row_addr    <= '0;
            vga.frame_start <= 1'b0;
        end else if (tick_c) begin
            h_cnt           <= h_nxt_c;
            v_cnt           <= v_nxt_c;
            vga.hsync       <= hsync_c;
            vga.vsync       <= vsync_c;
            vga.ready_sig   <= ready_c;
            vga.column_addr <= col_c;
            vga.row_addr    <= row_c;
            vga.frame_start <= frame_start_c;
        end
    end

endmodule
